// File: rtl/rv_alu_pkg.sv
// Shared encodings for the R-type ALU sequencer: opcode/funct constants,
// sequencer state encoding and the decoder's unit-select bundle.
package rv_alu_pkg;
    localparam logic [6:0] OPCODE_OP   = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;
    localparam logic [2:0] FUNCT3_SUB  = 3'h0;
    localparam logic [2:0] FUNCT3_SRA  = 3'h5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic base;
        logic extra;
        logic illegal;
    } unit_sel_t;
endpackage

// File: rtl/alu_rr_decode.sv
// Combinational funct7/funct3 decode into a one-hot {base, extra, illegal} select.
module alu_rr_decode
    import rv_alu_pkg::*;
(
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output unit_sel_t  sel
);
    always_comb begin
        sel = '0;
        if (funct7 == FUNCT7_BASE)
            sel.base = 1'b1;
        else if (funct7 == FUNCT7_ALT && (funct3 == FUNCT3_SUB || funct3 == FUNCT3_SRA))
            sel.extra = 1'b1;
        else
            sel.illegal = 1'b1;
    end
endmodule

// File: rtl/alu_rr_sequencer.sv
// One-at-a-time R-type sequencer: decode, strobe one ALU for a cycle, wait out
// its latency, then hold {rd, value} for writeback until accepted.
module alu_rr_sequencer
    import rv_alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_rs1_value,
    input  logic [31:0]      in_rs2_value,
    output logic             alu_base_enable,
    output logic             alu_extra_enable,
    output logic [2:0]       alu_funct3,
    output logic [31:0]      alu_rs1_value,
    output logic [31:0]      alu_rs2_value,
    input  logic [31:0]      alu_base_rd_value,
    input  logic [31:0]      alu_extra_rd_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_value,
    output logic             out_illegal,
    output logic [CNT_W-1:0] retired_count
);
    localparam int LAT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    seq_state_t       state, state_nxt;
    unit_sel_t        dec;
    logic             sel_extra;
    logic [LAT_W-1:0] lat_cnt;
    logic             accept;

    alu_rr_decode u_decode (
        .funct7 (in_funct7),
        .funct3 (in_funct3),
        .sel    (dec)
    );

    // flush blocks acceptance in the same cycle it aborts the current op
    assign in_ready         = (state == ST_IDLE) && !flush;
    assign accept           = in_valid && in_ready;
    assign alu_base_enable  = (state == ST_ISSUE) && !sel_extra;
    assign alu_extra_enable = (state == ST_ISSUE) &&  sel_extra;
    assign out_valid        = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept) state_nxt = (dec.base || dec.extra) ? ST_ISSUE : ST_DONE;
                ST_ISSUE: state_nxt = ST_WAIT;
                ST_WAIT:  if (lat_cnt == '0) state_nxt = ST_DONE;
                ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_funct3    <= '0;
            alu_rs1_value <= '0;
            alu_rs2_value <= '0;
            out_rd        <= '0;
            out_value     <= '0;
            out_illegal   <= 1'b0;
            sel_extra     <= 1'b0;
            lat_cnt       <= '0;
            retired_count <= '0;
        end else begin
            if (accept) begin
                alu_funct3    <= in_funct3;
                alu_rs1_value <= in_rs1_value;
                alu_rs2_value <= in_rs2_value;
                out_rd        <= in_rd;
                sel_extra     <= dec.extra;
                out_illegal   <= dec.illegal;
                if (dec.illegal) out_value <= '0;
            end
            if (state == ST_ISSUE)
                lat_cnt <= LAT_W'(ALU_LATENCY - 1);
            if (state == ST_WAIT && !flush) begin
                if (lat_cnt == '0)
                    out_value <= sel_extra ? alu_extra_rd_value : alu_base_rd_value;
                else
                    lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (state == ST_DONE && out_ready && !flush)
                retired_count <= retired_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Randomized bench for alu_rr_sequencer with behavioural ALUs and a
// specification-level reference for decode, results, latency and retire count.
module tb_alu_rr_sequencer;
    localparam int LAT = 1;
    localparam int CW  = 16;

    logic          clock = 1'b0;
    logic          reset, flush, in_valid, in_ready;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [4:0]    in_rd;
    logic [31:0]   in_rs1_value, in_rs2_value;
    logic          alu_base_enable, alu_extra_enable;
    logic [2:0]    alu_funct3;
    logic [31:0]   alu_rs1_value, alu_rs2_value;
    logic [31:0]   alu_base_rd_value, alu_extra_rd_value;
    logic          out_valid, out_ready, out_illegal;
    logic [4:0]    out_rd;
    logic [31:0]   out_value;
    logic [CW-1:0] retired_count;

    int n_chk = 0;
    int n_err = 0;
    int exp_count = 0;

    always #5 clock = ~clock;

    alu_rr_sequencer #(.ALU_LATENCY(LAT), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
        .in_rs1_value(in_rs1_value), .in_rs2_value(in_rs2_value),
        .alu_base_enable(alu_base_enable), .alu_extra_enable(alu_extra_enable),
        .alu_funct3(alu_funct3), .alu_rs1_value(alu_rs1_value), .alu_rs2_value(alu_rs2_value),
        .alu_base_rd_value(alu_base_rd_value), .alu_extra_rd_value(alu_extra_rd_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_value(out_value), .out_illegal(out_illegal), .retired_count(retired_count)
    );

    function automatic logic is_illegal(input logic [6:0] f7, input logic [2:0] f3);
        return !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    endfunction

    // RV32 R-type semantics; 0 for undecodable ops
    function automatic logic [31:0] ref_val(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        if (f7 == 7'h00) begin
            case (f3)
                3'd0: r = a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
            r = a - b;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
            r = $unsigned($signed(a) >>> b[4:0]);
        end
        return r;
    endfunction

    // single-cycle registered ALUs
    always @(posedge clock) begin
        if (alu_base_enable)
            alu_base_rd_value <= ref_val(7'h00, alu_funct3, alu_rs1_value, alu_rs2_value);
        if (alu_extra_enable)
            alu_extra_rd_value <= ref_val(7'h20, alu_funct3, alu_rs1_value, alu_rs2_value);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [6:0] f7, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid = 1'b1; in_funct7 = f7; in_funct3 = f3;
        in_rs1_value = a; in_rs2_value = b; in_rd = rd;
    endtask

    task automatic do_op(input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int stall);
        logic        il;
        logic [31:0] ev;
        int          k, nb, ne, nboth;
        logic        seen;
        il = is_illegal(f7, f3);
        ev = ref_val(f7, f3, a, b);
        @(negedge clock);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        drive_req(f7, f3, a, b, rd);
        @(posedge clock);
        #1 in_valid = 1'b0;
        k = 0; nb = 0; ne = 0; nboth = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            k++;
            nb += int'(alu_base_enable);
            ne += int'(alu_extra_enable);
            nboth += int'(alu_base_enable && alu_extra_enable);
            if (k == 1) chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
            seen = out_valid;
        end
        chk("latency", k, il ? 32'd1 : 32'(LAT + 2));
        chk("base_en_cycles", nb, {31'b0, !il && f7 == 7'h00});
        chk("extra_en_cycles", ne, {31'b0, !il && f7 == 7'h20});
        chk("both_en", nboth, 32'd0);
        for (int s = 0; s < stall; s++) begin
            chk("hold_ctl", {24'b0, out_valid, in_ready, out_illegal, out_rd},
                {24'b0, 1'b1, 1'b0, il, rd});
            chk("hold_value", out_value, ev);
            @(negedge clock);
        end
        out_ready = 1'b1;
        chk("out_value", out_value, ev);
        chk("out_rd_ill", {26'b0, out_illegal, out_rd}, {26'b0, il, rd});
        @(posedge clock);
        #1 out_ready = 1'b0;
        exp_count++;
        @(negedge clock);
        chk("retired_count", {16'b0, retired_count}, 32'(exp_count & 16'hFFFF));
        chk("back_idle", {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [6:0] f7;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_funct3 = '0; in_funct7 = '0; in_rd = '0; in_rs1_value = '0; in_rs2_value = '0;
        repeat (2) @(negedge clock);
        chk("rst_ctl", {22'b0, alu_base_enable, alu_extra_enable, out_valid, out_illegal,
                        alu_funct3, in_ready}, 32'd1);
        chk("rst_data", out_value | alu_rs1_value | alu_rs2_value | {27'b0, out_rd}, 32'd0);
        chk("rst_count", {16'b0, retired_count}, 32'd0);
        reset = 1'b0;

        // directed cases
        do_op(7'h20, 3'd0, 32'd10, 32'd3, 5'd5, 0);
        do_op(7'h20, 3'd5, 32'h8000_0000, 32'd4, 5'd7, 1);
        do_op(7'h20, 3'd1, 32'd1, 32'd2, 5'd9, 0);
        do_op(7'h00, 3'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 5);

        // flush while waiting on the ALU, with a competing request in the flush cycle
        @(negedge clock);
        drive_req(7'h20, 3'd0, 32'd50, 32'd8, 5'd3);
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        flush = 1'b1;
        drive_req(7'h00, 3'd4, 32'd1, 32'd2, 5'd4);
        @(posedge clock);
        #1 begin flush = 1'b0; in_valid = 1'b0; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("flush_wait_idle", {29'b0, out_valid, in_ready, alu_base_enable | alu_extra_enable},
                32'd2);
        end
        chk("flush_wait_count", {16'b0, retired_count}, 32'(exp_count));

        // flush beats out_ready in DONE
        @(negedge clock);
        drive_req(7'h20, 3'd7, 32'd1, 32'd1, 5'd6);
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        chk("pre_flush_done", {31'b0, out_valid}, 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        #1 begin flush = 1'b0; out_ready = 1'b0; end
        @(negedge clock);
        chk("flush_done_idle", {30'b0, out_valid, in_ready}, 32'd1);
        chk("flush_done_count", {16'b0, retired_count}, 32'(exp_count));

        // reset while in ISSUE
        @(negedge clock);
        drive_req(7'h00, 3'd6, 32'hF0, 32'h0F, 5'd2);
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        chk("issue_before_rst", {31'b0, alu_base_enable}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_en", {29'b0, alu_base_enable, alu_extra_enable, out_valid}, 32'd0);
        chk("rst_mid_data", {16'b0, retired_count} | alu_rs1_value, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_count = 0;
        do_op(7'h00, 3'd0, 32'd2, 32'd2, 5'd1, 0);

        // randomized ops
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1, 2:    f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            do_op(f7, 3'($urandom), $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 31)),
                  5'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
